// File: rtl/rv6_pkg.sv
// rtl/rv6_pkg.sv - shared AMO sequencer types, field codes and uop encoders (AMO_LRSC_EN adds lr/sc states)
package rv6_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_L,
        ST_OP,
        ST_STORE,
        ST_WAIT_S,
        ST_WB
`ifdef AMO_LRSC_EN
        , ST_SC_ST,
        ST_SC_OK,
        ST_SC_FAIL
`endif
    } amo_state_e;

    localparam logic [6:0] OPC_AMO   = 7'b0101111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_W      = 3'b010;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;

    localparam logic [4:0]  REG_T0  = 5'd30;
    localparam logic [4:0]  REG_T1  = 5'd31;
    localparam logic [31:0] UOP_NOP = 32'h00000013;

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, F3_W, rd, OPC_LOAD};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, F3_W, 5'd0, OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_r(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OPC_OPIMM};
    endfunction

    function automatic logic is_amo_f5(input logic [31:0] ir, input logic [4:0] f5);
        return (ir[6:0] == OPC_AMO) && (ir[14:12] == F3_W) && (ir[31:27] == f5);
    endfunction

    // Only these five are cracked; every other AMO-space encoding reaches decode untouched.
    function automatic logic is_amo_op(input logic [31:0] ir);
        return is_amo_f5(ir, F5_ADD) || is_amo_f5(ir, F5_SWAP) || is_amo_f5(ir, F5_XOR) ||
               is_amo_f5(ir, F5_AND) || is_amo_f5(ir, F5_OR);
    endfunction

endpackage

// File: rtl/amo_uop_gen.sv
// rtl/amo_uop_gen.sv - combinational (state, ir_in) to micro-op encoder for the AMO sequencer
module amo_uop_gen
    import rv6_pkg::*;
(
    input  logic [3:0]  state,
    input  logic [31:0] ir_in,
    output logic [31:0] uop_out
);

    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] f5;
    logic [2:0] op_f3;

    assign rd  = ir_in[11:7];
    assign rs1 = ir_in[19:15];
    assign rs2 = ir_in[24:20];
    assign f5  = ir_in[31:27];

    always_comb begin
        op_f3 = 3'b000;
        case (f5)
            F5_XOR:  op_f3 = 3'b100;
            F5_OR:   op_f3 = 3'b110;
            F5_AND:  op_f3 = 3'b111;
            default: op_f3 = 3'b000;
        endcase
    end

    always_comb begin
        uop_out = UOP_NOP;
        case (amo_state_e'(state))
`ifdef AMO_LRSC_EN
            ST_IDLE:    uop_out = is_amo_f5(ir_in, F5_LR) ? enc_lw(rd, rs1) : ir_in;
            ST_SC_ST:   uop_out = enc_sw(rs2, rs1);
            ST_SC_OK:   uop_out = enc_addi(rd, 5'd0, 12'd0);
            ST_SC_FAIL: uop_out = enc_addi(rd, 5'd0, 12'd1);
`else
            ST_IDLE:    uop_out = ir_in;
`endif
            ST_LOAD:    uop_out = enc_lw(REG_T0, rs1);
            ST_OP:      uop_out = enc_r(op_f3, REG_T1, REG_T0, rs2);
            ST_STORE:   uop_out = (f5 == F5_SWAP) ? enc_sw(rs2, rs1) : enc_sw(REG_T1, rs1);
            ST_WB:      uop_out = enc_addi(rd, REG_T0, 12'd0);
            default:    uop_out = UOP_NOP;
        endcase
    end

endmodule

// File: rtl/amo_seq.sv
// rtl/amo_seq.sv - cracks RV AMO instructions into load/op/store/writeback uops (AMO_LRSC_EN adds lr.w/sc.w)
module amo_seq
    import rv6_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     ir_in,
    input  logic            ir_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            mem_done,
    input  logic            resv_clr,
    output logic [31:0]     uop_out,
    output logic            uop_valid,
    output logic            fetch_hold
);

    amo_state_e  state_q, state_d;
    logic [31:0] gen_uop;
    logic        amo_hit;
    logic        sc_hit;
    logic        rd_zero;
    logic        is_swap;
    logic        issue;
    logic        last;
    logic        abort;

    assign amo_hit = ir_valid && is_amo_op(ir_in);
    assign rd_zero = (ir_in[11:7] == 5'd0);
    assign is_swap = (ir_in[31:27] == F5_SWAP);
    assign abort   = flush && (state_q == ST_LOAD || state_q == ST_WAIT_L || state_q == ST_OP);

`ifdef AMO_LRSC_EN
    logic            resv_q, resv_d;
    logic [XLEN-1:0] resv_addr_q, resv_addr_d;
    logic            lr_hit;
    logic            sc_ok;

    assign lr_hit = ir_valid && is_amo_f5(ir_in, F5_LR);
    assign sc_hit = ir_valid && is_amo_f5(ir_in, F5_SC);
    // A snoop landing in the same cycle as the sc decision must make it fail.
    assign sc_ok  = resv_q && (resv_addr_q == rs1_val) && !resv_clr;

    always_comb begin
        resv_d      = resv_q;
        resv_addr_d = resv_addr_q;
        if (state_q == ST_IDLE && lr_hit && !stall && !flush) begin
            resv_d      = 1'b1;
            resv_addr_d = rs1_val;
        end
        if (resv_clr || flush || (state_q == ST_IDLE && sc_hit)) begin
            resv_d = 1'b0;
        end
    end
`else
    logic unused_lrsc_inputs;
    assign sc_hit             = 1'b0;
    assign unused_lrsc_inputs = ^{rs1_val, resv_clr};
`endif

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (amo_hit && !flush) begin
                    state_d = ST_LOAD;
                end
`ifdef AMO_LRSC_EN
                else if (sc_hit && !flush) begin
                    state_d = sc_ok ? ST_SC_ST : ST_SC_FAIL;
                end
`endif
            end
            ST_LOAD: begin
                issue = 1'b1;
                if (flush)       state_d = ST_IDLE;
                else if (!stall) state_d = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (flush)         state_d = ST_IDLE;
                else if (mem_done) state_d = is_swap ? ST_STORE : ST_OP;
            end
            ST_OP: begin
                issue = 1'b1;
                if (flush)       state_d = ST_IDLE;
                else if (!stall) state_d = ST_STORE;
            end
            ST_STORE: begin
                issue = 1'b1;
                if (!stall) state_d = ST_WAIT_S;
            end
            ST_WAIT_S: begin
                if (mem_done) begin
`ifdef AMO_LRSC_EN
                    if (is_amo_f5(ir_in, F5_SC)) begin
                        state_d = ST_SC_OK;
                    end else
`endif
                    if (rd_zero) begin
                        state_d = ST_IDLE;
                        last    = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                issue = 1'b1;
                if (!stall) begin
                    state_d = ST_IDLE;
                    last    = 1'b1;
                end
            end
`ifdef AMO_LRSC_EN
            ST_SC_ST: begin
                issue = 1'b1;
                if (!stall) state_d = ST_WAIT_S;
            end
            ST_SC_OK, ST_SC_FAIL: begin
                issue = 1'b1;
                if (!stall) begin
                    state_d = ST_IDLE;
                    last    = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
`ifdef AMO_LRSC_EN
            resv_q      <= 1'b0;
            resv_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef AMO_LRSC_EN
            resv_q      <= resv_d;
            resv_addr_q <= resv_addr_d;
`endif
        end
    end

    amo_uop_gen u_gen (
        .state   (state_q),
        .ir_in   (ir_in),
        .uop_out (gen_uop)
    );

    // Outputs are gated by rst_n so reset takes effect in the same cycle it is asserted.
    always_comb begin
        uop_out = rst_n ? gen_uop : UOP_NOP;
        if (state_q == ST_IDLE) begin
            uop_valid = rst_n && ir_valid && !amo_hit && !sc_hit;
        end else begin
            uop_valid = rst_n && issue;
        end
        fetch_hold = rst_n && !abort && !last &&
                     ((state_q != ST_IDLE) || ((amo_hit || sc_hit) && !flush));
    end

endmodule
